// File: rtl/regfile_alu_core_if.sv
// Instruction/result bundle between the sequencer (master) and the regfile/ALU core (slave).
interface regfile_alu_core_if #(
  parameter int WIDTH = 4,
  parameter int NREGS = 16
);
  localparam int AW = $clog2(NREGS);

  logic             instr_valid;
  logic             instr_ready;
  logic [2:0]       opcode;
  logic [AW-1:0]    rd;
  logic [AW-1:0]    rs1;
  logic [AW-1:0]    rs2;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             cf;
  logic             sf;
  logic             zf;
  logic             invalid;

  modport master (
    output instr_valid, opcode, rd, rs1, rs2, imm,
    input  instr_ready, result, result_valid, cf, sf, zf, invalid
  );

  modport slave (
    input  instr_valid, opcode, rd, rs1, rs2, imm,
    output instr_ready, result, result_valid, cf, sf, zf, invalid
  );
endinterface

// File: rtl/regfile_alu_core.sv
// Multi-cycle regfile + ALU: IDLE->READ->EXEC->WB, result_valid one cycle after the WB edge.
// Accepts one instruction per 4 cycles; instr_ready is low while an instruction is in flight.
module regfile_alu_core #(
  parameter int WIDTH = 4,
  parameter int NREGS = 16,
  localparam int AW = $clog2(NREGS)
) (
  input logic              clk,
  input logic              rst,
  regfile_alu_core_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LOAD = 3'b100;

  state_t           state_q, state_d;
  logic             ready;
  logic             accept;

  logic [2:0]       op_q;
  logic [AW-1:0]    rd_q, rs1_q, rs2_q;
  logic [WIDTH-1:0] imm_q, a_q, b_q;
  logic [WIDTH-1:0] rf_q [NREGS];

  logic [WIDTH-1:0] alu_res_d, ex_res_q;
  logic             alu_cf_d, alu_sf_d, alu_zf_d, alu_inv_d;
  logic             ex_cf_q, ex_sf_q, ex_zf_q, ex_inv_q;
  logic [WIDTH:0]   sum;

  logic [WIDTH-1:0] result_q;
  logic             result_valid_q, cf_q, sf_q, zf_q, invalid_q;

  assign accept = bus.instr_valid && ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == S_IDLE);
  end

  assign sum = {1'b0, a_q} + {1'b0, b_q};

  // SUB reports magnitude with sf marking a negative difference.
  always_comb begin
    alu_res_d = '0;
    alu_cf_d  = 1'b0;
    alu_sf_d  = 1'b0;
    alu_inv_d = 1'b0;
    case (op_q)
      OP_AND:  alu_res_d = a_q & b_q;
      OP_OR:   alu_res_d = a_q | b_q;
      OP_ADD:  {alu_cf_d, alu_res_d} = sum;
      OP_SUB: begin
        if (a_q < b_q) begin
          alu_res_d = b_q - a_q;
          alu_sf_d  = 1'b1;
        end else begin
          alu_res_d = a_q - b_q;
        end
      end
      OP_LOAD: alu_res_d = imm_q;
      default: alu_inv_d = 1'b1;
    endcase
    alu_zf_d = !alu_inv_d && (alu_res_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q           <= '0;
      rd_q           <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      imm_q          <= '0;
      a_q            <= '0;
      b_q            <= '0;
      ex_res_q       <= '0;
      ex_cf_q        <= 1'b0;
      ex_sf_q        <= 1'b0;
      ex_zf_q        <= 1'b0;
      ex_inv_q       <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      cf_q           <= 1'b0;
      sf_q           <= 1'b0;
      zf_q           <= 1'b0;
      invalid_q      <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      result_valid_q <= (state_q == S_WB);
      if (accept) begin
        op_q  <= bus.opcode;
        rd_q  <= bus.rd;
        rs1_q <= bus.rs1;
        rs2_q <= bus.rs2;
        imm_q <= bus.imm;
      end
      if (state_q == S_READ) begin
        a_q <= rf_q[rs1_q];
        b_q <= rf_q[rs2_q];
      end
      if (state_q == S_EXEC) begin
        ex_res_q <= alu_res_d;
        ex_cf_q  <= alu_cf_d;
        ex_sf_q  <= alu_sf_d;
        ex_zf_q  <= alu_zf_d;
        ex_inv_q <= alu_inv_d;
      end
      if (state_q == S_WB) begin
        if (!ex_inv_q) rf_q[rd_q] <= ex_res_q;
        result_q  <= ex_res_q;
        cf_q      <= ex_cf_q;
        sf_q      <= ex_sf_q;
        zf_q      <= ex_zf_q;
        invalid_q <= ex_inv_q;
      end
    end
  end

  assign bus.instr_ready  = ready;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.cf           = cf_q;
  assign bus.sf           = sf_q;
  assign bus.zf           = zf_q;
  assign bus.invalid      = invalid_q;
endmodule

// File: doc/regfile_alu_core.md
Name: regfile_alu_core

Overview:
- Parametrised, multi-cycle register-file + ALU core; next generation of the 4-bit regfile/ALU processor pair.
- Accepts one instruction at a time over a valid/ready handshake, reads two source registers, executes AND/OR/ADD/SUB/LOAD, writes back to a destination register, and reports result plus carry/sign/zero flags.
- Sits between the instruction sequencer and the status/display logic.

Parameters:
- WIDTH, 4, datapath and register width in bits (>=2)
- NREGS, 16, number of registers (power of two, >=2)
- AW, $clog2(NREGS), register address width (derived; not overridden)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- instr_valid  input  1  instruction present on opcode/rd/rs1/rs2/imm
- instr_ready  output  1  core can accept an instruction
- opcode  input  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 LOAD, 101-111 invalid
- rd  input  AW  destination register
- rs1  input  AW  source register A
- rs2  input  AW  source register B
- imm  input  WIDTH  immediate for LOAD
- result  output  WIDTH  registered result of last completed instruction
- result_valid  output  1  one-cycle pulse when result/flags update
- cf  output  1  carry flag
- sf  output  1  sign flag (SUB negative)
- zf  output  1  zero flag
- invalid  output  1  last completed instruction had an illegal opcode

Behaviour:
- Reset: all NREGS registers = 0; state IDLE; instr_ready=1; result=0; result_valid=0; cf=sf=zf=invalid=0.
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE.
  - IDLE: instr_ready=1. The handshake fires when instr_valid && instr_ready. On that cycle, opcode/rd/rs1/rs2/imm are latched and the FSM moves to READ. Inputs are ignored in all other states.
  - READ: file[rs1] and file[rs2] are latched into operand registers A and B.
  - EXEC: the ALU computes a WIDTH+1-bit result and the flags into pipeline registers.
  - WB: rd is written (legal opcodes only); result, flags and invalid are updated; result_valid=1 for this cycle only. Next state is IDLE.
- Latency: handshake at edge T -> result_valid high in the cycle after edge T+3. Throughput is one instruction per 4 cycles. instr_ready=0 in READ, EXEC and WB.
- Arithmetic:
  - AND/OR: bitwise; cf=0, sf=0.
  - ADD: {cf, result} = A + B, unsigned, with carry-out in cf; sf=0.
  - SUB: computed as A - B unsigned. If A < B: sf=1 and result = B - A (magnitude); otherwise sf=0 and result = A - B. cf=0 in both cases.
  - LOAD: result = imm, written to rd; cf=0, sf=0.
  - zf = (result == 0) for all legal opcodes.
- Invalid opcode (101-111):
  - No register write.
  - result=0, cf=sf=zf=0, invalid=1, result_valid pulses normally in WB.
  - invalid is cleared by the next legal completion.
- Outputs result/cf/sf/zf/invalid hold their values between completions.
- Hazards: an instruction whose rs1/rs2 equals the previous rd sees the written value, because READ always follows the previous WB. No forwarding is needed.
- rs1 == rs2 is legal; both operands read the same register.
- rd == rs1 is legal: the old value is used as the operand, the new value is written.
- Wrap-around: ADD overflow wraps result modulo 2^WIDTH with cf=1.
- Reset mid-operation: rst in READ/EXEC/WB aborts the instruction. No write occurs and result_valid stays 0. Registers and outputs take their reset values, and the FSM is in IDLE at the next cycle.
- rst and instr_valid asserted together: rst wins and the instruction is not accepted.
- The register file is not readable externally; observation is only through instruction results.

Test Plan:
- Reset, then LOAD r1=5, LOAD r2=3, ADD r3=r1+r2 -> third result_valid gives result=8, cf=0, zf=0; instr_ready low exactly 3 cycles after each accept.
- WIDTH=4: LOAD r1=12, LOAD r2=7, ADD r4=r1+r2 -> result=3, cf=1; then SUB r5=r2-r1 -> result=5, sf=1, cf=0.
- SUB r6=r1-r1 with r1=9 -> result=0, zf=1, sf=0; AND r7 with r1=1010, r2=0101 -> result=0000, zf=1; OR of the same -> 1111.
- Opcode 110 with rd=r1 after r1=9 -> invalid=1, result=0, result_valid pulses; a following OR r8=r1|r1 returns 9 and invalid=0.
- rst asserted in EXEC of LOAD r2=7 -> no result_valid, all outputs 0 next cycle, a subsequent OR r9=r2|r2 returns 0.
- instr_valid held high continuously -> exactly one accept per 4 cycles. Fields changed while busy are ignored. Run the back-to-back dependency chain with WIDTH=8, NREGS=32: LOAD r31=200, ADD r30=r31+r31 -> result=144, cf=1.
